// File: rtl/ram_shift_reg_ctrl.sv
// ram_shift_reg_ctrl: sequencer for a RAM-based variable-length delay line.
// Runs a 1R1W sync-read RAM as a circular buffer and flags valid output.
module ram_shift_reg_ctrl #(
    parameter int DSIZE   = 1,
    parameter int WDEPTH  = 1024,
    parameter int ASIZE   = $clog2(WDEPTH),
    parameter int DEF_LEN = 4,
    parameter bit CLR_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [DSIZE-1:0] din,
    input  logic [ASIZE-1:0] len_i,
    input  logic             len_load,
    output logic             ready,
    output logic             ram_we,
    output logic [ASIZE-1:0] ram_waddr,
    output logic [DSIZE-1:0] ram_wdata,
    output logic             ram_re,
    output logic [ASIZE-1:0] ram_raddr,
    output logic             q_valid,
    output logic [ASIZE-1:0] len_cur
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_FILL,
        ST_RUN
    } state_t;

    localparam logic [ASIZE-1:0] ONE       = ASIZE'(1);
    localparam logic [ASIZE-1:0] LEN_MIN   = ASIZE'(2);
    localparam logic [ASIZE-1:0] LEN_DEF   = ASIZE'(DEF_LEN);
    localparam logic [ASIZE-1:0] ADDR_LAST = ASIZE'(WDEPTH - 1);
    localparam state_t ST_INIT = CLR_EN ? ST_CLEAR : ST_FILL;

    state_t           state;
    state_t           state_nxt;
    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] clr_cnt;
    logic [ASIZE-1:0] fill_cnt;
    logic [ASIZE-1:0] len_q;
    logic [ASIZE-1:0] len_clamped;
    logic             shift;
    logic             fill_last;
    logic             clr_last;
    logic             clearing;

    assign clearing    = (state == ST_CLEAR);
    assign shift       = en && !clearing;
    assign fill_last   = (fill_cnt == len_q - ONE);
    assign clr_last    = (clr_cnt == ADDR_LAST);
    assign len_clamped = (len_i < LEN_MIN) ? LEN_MIN : len_i;
    assign len_cur     = len_q;
    assign ready       = !clearing;

    // State register; reset restarts the clear sweep (or fill if clear is off).
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: clear sweep -> fill -> run; a length load re-enters fill.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (clr_last) state_nxt = ST_FILL;
            ST_FILL:  if (shift && fill_last) state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_RUN;
            default:  state_nxt = ST_INIT;
        endcase
        if (len_load && !clearing) begin
            state_nxt = ST_FILL;
        end
    end

    // RAM port drive: zero-fill during clear, one write+read per shift after.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wptr;
        ram_wdata = din;
        ram_re    = 1'b0;
        ram_raddr = wptr - len_q + ONE;
        if (clearing) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = '0;
        end else if (shift) begin
            ram_we = 1'b1;
            ram_re = 1'b1;
        end
    end

    // Pointers, counters, length and valid flag; length load overrides shift.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wptr     <= '0;
            clr_cnt  <= '0;
            fill_cnt <= '0;
            len_q    <= LEN_DEF;
            q_valid  <= 1'b0;
        end else begin
            if (clearing) begin
                clr_cnt <= clr_cnt + ONE;
                q_valid <= 1'b0;
            end
            if (shift) begin
                wptr    <= wptr + ONE;
                q_valid <= (state == ST_RUN) || fill_last;
                if (state == ST_FILL) begin
                    fill_cnt <= fill_cnt + ONE;
                end
            end
            if (len_load) begin
                len_q <= len_clamped;
                if (!clearing) begin
                    fill_cnt <= '0;
                    q_valid  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_shift_reg_ctrl.sv
// tb_ram_shift_reg_ctrl: scoreboard bench for the delay-line sequencer,
// with a behavioural sync-read RAM attached to the RAM ports.
module tb_ram_shift_reg_ctrl;

    localparam int DSIZE  = 16;
    localparam int WDEPTH = 1024;
    localparam int ASIZE  = 10;

    logic             clk = 1'b0;
    logic             Reset;
    logic             en;
    logic [DSIZE-1:0] din;
    logic [ASIZE-1:0] len_i;
    logic             len_load;
    logic             ready;
    logic             ram_we;
    logic [ASIZE-1:0] ram_waddr;
    logic [DSIZE-1:0] ram_wdata;
    logic             ram_re;
    logic [ASIZE-1:0] ram_raddr;
    logic             q_valid;
    logic [ASIZE-1:0] len_cur;
    logic [DSIZE-1:0] ram_dout;
    logic [DSIZE-1:0] mem [WDEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    int m_state;
    int m_clr;
    int m_wptr;
    int m_fill;
    int m_len;
    bit m_qv;
    bit checking;
    logic [DSIZE-1:0] hist [$];
    logic [DSIZE-1:0] exp_q [$];
    logic [DSIZE-1:0] exp_dout;
    logic [DSIZE-1:0] cnt;

    ram_shift_reg_ctrl #(
        .DSIZE  (DSIZE),
        .WDEPTH (WDEPTH),
        .ASIZE  (ASIZE),
        .DEF_LEN(4),
        .CLR_EN (1'b1)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .en       (en),
        .din      (din),
        .len_i    (len_i),
        .len_load (len_load),
        .ready    (ready),
        .ram_we   (ram_we),
        .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata),
        .ram_re   (ram_re),
        .ram_raddr(ram_raddr),
        .q_valid  (q_valid),
        .len_cur  (len_cur)
    );

    always #5 clk = ~clk;

    // Sync-read RAM; dout holds while read enable is low.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit e, input logic [DSIZE-1:0] d,
                        input bit ll, input int li);
        bit v;
        int nl;
        @(negedge clk);
        if (checking) begin
            if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
            chk("ready", ready, m_state != 0);
            chk("q_valid", q_valid, m_qv);
            chk("len_cur", len_cur, m_len);
            if (m_qv) chk("dout", ram_dout, exp_dout);
        end
        Reset    = rst;
        en       = e;
        din      = d;
        len_load = ll;
        len_i    = li[ASIZE-1:0];
        #1;
        if (!rst && checking) begin
            if (m_state == 0) begin
                chk("clr_we", ram_we, 1);
                chk("clr_waddr", ram_waddr, m_clr);
                chk("clr_wdata", ram_wdata, 0);
                chk("clr_re", ram_re, 0);
            end else begin
                chk("we", ram_we, e);
                chk("re", ram_re, e);
                if (e) begin
                    chk("waddr", ram_waddr, m_wptr);
                    chk("wdata", ram_wdata, d);
                    chk("raddr", ram_raddr, (m_wptr - m_len + 1 + WDEPTH) % WDEPTH);
                end
            end
        end
        if (rst) begin
            m_state = 0;
            m_clr = 0;
            m_wptr = 0;
            m_fill = 0;
            m_len = 4;
            m_qv = 0;
            hist.delete();
            exp_q.delete();
            checking = 1;
            return;
        end
        nl = (li < 2) ? 2 : li;
        if (m_state == 0) begin
            if (ll) m_len = nl;
            if (m_clr == WDEPTH - 1) m_state = 1;
            m_clr = (m_clr + 1) % WDEPTH;
        end else begin
            if (e) begin
                v = (m_state == 2) || (m_fill == m_len - 1);
                hist.push_back(d);
                if (v) exp_q.push_back(hist[hist.size() - m_len]);
                m_qv = v;
                m_wptr = (m_wptr + 1) % WDEPTH;
                if (m_state == 1) begin
                    if (m_fill == m_len - 1) m_state = 2;
                    m_fill++;
                end
            end
            if (ll) begin
                m_len = nl;
                m_fill = 0;
                m_state = 1;
                m_qv = 0;
                exp_q.delete();
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        en = 1'b0;
        din = '0;
        len_load = 1'b0;
        len_i = '0;
        checking = 0;
        exp_dout = '0;
        cnt = '0;
        step(1, 0, 0, 0, 0);
        // Clear sweep with en high and length loads along the way.
        for (int i = 0; i < 1024; i++) begin
            step(0, 1, 16'hffff, (i == 500) || (i == 900), (i == 500) ? 5 : 4);
        end
        // Fill and run at length 4 across a pointer wrap.
        for (int i = 0; i < 1100; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        // Mid-run length change to 15, then clamped lengths.
        step(0, 1, cnt, 1, 15);
        cnt++;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        step(0, 1, cnt, 1, 0);
        cnt++;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        step(0, 1, cnt, 1, 1);
        cnt++;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        // Length 8 with en toggling every 3 cycles.
        step(0, 1, cnt, 1, 8);
        cnt++;
        for (int i = 0; i < 90; i++) begin
            bit e;
            e = ((i / 3) % 2) == 0;
            step(0, e, cnt, 0, 0);
            if (e) cnt++;
        end
        // Reset mid-fill at length 15, with a competing length load.
        step(0, 1, cnt, 1, 15);
        cnt++;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        step(1, 1, cnt, 1, 20);
        for (int i = 0; i < 1024; i++) begin
            step(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1, cnt, 0, 0);
            cnt++;
        end
        step(0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
